// File: rtl/tracker_pkg.sv
// Shared definitions for the orange centroid tracker.
//   - Width constants for the x coordinate, pixel count and coordinate sum.
//   - Direction code enum (the value published on `direction`).
//   - Tracker FSM state enum.
//   - zone_dir(): maps a centroid x to its steering zone.
package tracker_pkg;

  localparam int X_W   = 10;
  localparam int CNT_W = 19;
  localparam int SUM_W = 28;

  typedef enum logic [2:0] {
    DIR_NONE       = 3'd0,
    DIR_HARD_LEFT  = 3'd1,
    DIR_LEFT       = 3'd2,
    DIR_CENTRE     = 3'd3,
    DIR_RIGHT      = 3'd4,
    DIR_HARD_RIGHT = 3'd5
  } dir_e;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_DIV = 2'd1,
    ST_PUB = 2'd2
  } state_e;

  // Five equal-width zones; boundaries are the integer-divided fifths of
  // the active line width.
  function automatic dir_e zone_dir(input logic [X_W-1:0] cx, input int h_active);
    int c;
    c = int'(cx);
    if (c < h_active / 5)          return DIR_HARD_LEFT;
    else if (c < 2 * h_active / 5) return DIR_LEFT;
    else if (c < 3 * h_active / 5) return DIR_CENTRE;
    else if (c < 4 * h_active / 5) return DIR_RIGHT;
    else                           return DIR_HARD_RIGHT;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load dividend/divisor and begin (ignored while busy)
//   dividend    : DIVIDEND_W-bit numerator
//   divisor     : DIVISOR_W-bit denominator (zero yields an all-ones quotient)
//   done        : one-cycle pulse once the quotient is final
//   quotient    : result, held until the next start
// The divide takes DIVIDEND_W cycles after the start edge; done is
// registered on the edge of the last iteration.
module seq_divider #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int IW = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;
  logic               fits;

  always_comb begin
    shifted = {rem_q, quo_q[DIVIDEND_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    iter_d = iter_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (busy_q) begin
      // Restoring step: keep the subtraction only when it does not go negative.
      rem_d  = fits ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
      quo_d  = {quo_q[DIVIDEND_W-2:0], fits};
      iter_d = iter_q - IW'(1);
      if (iter_q == IW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      iter_d = IW'(DIVIDEND_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/orange_centroid_tracker.sv
// Frame-level orange centroid tracker (VGA pixel clock domain).
// Accumulates the count and x-sum of orange pixels over a frame, divides
// at frame end and publishes target-present, steering direction, centroid
// and pixel count once per frame.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   active          : visible-pixel qualifier
//   vsync           : vertical sync (active low); its falling edge ends a frame
//   is_orange       : orange mask for the current pixel
//   orange_detected : last frame had >= MIN_PIXELS orange pixels
//   direction       : steering zone code (000 when no target)
//   centroid_x      : centroid of the last detected frame (held otherwise)
//   orange_count    : pixel count of the last completed frame
//   frame_valid     : one-cycle pulse when the outputs above update
//   overrun         : sticky, a frame end arrived while still dividing/publishing
// Build option: define CENTROID_HYST_EN to require a new non-none direction
// on two consecutive frames before `direction` follows it.
module orange_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int MIN_PIXELS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             vsync,
  input  logic             is_orange,
  output logic             orange_detected,
  output logic [2:0]       direction,
  output logic [X_W-1:0]   centroid_x,
  output logic [CNT_W-1:0] orange_count,
  output logic             frame_valid,
  output logic             overrun
);

  localparam logic [X_W-1:0]   X_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam int               CX_MAX  = (H_ACTIVE - 1 > 1023) ? 1023 : H_ACTIVE - 1;
  localparam logic [SUM_W-1:0] CX_LIM  = SUM_W'(CX_MAX);

  logic             vsync_q;
  logic [X_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic             fe_pend_q, fe_pend_d;
  state_e           state_q, state_d;
  logic             det_q, det_d;
  dir_e             dir_q, dir_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             fv_q, fv_d;
  logic             ovr_q, ovr_d;
`ifdef CENTROID_HYST_EN
  dir_e             pend_q, pend_d;
`endif

  logic             frame_end;
  logic             pix;
  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] quo;
  logic [X_W-1:0]   cx_clamp;
  logic [SUM_W:0]   sum_wide;
  logic [CNT_W-1:0] cnt_inc;
  logic [SUM_W-1:0] sum_inc;
  dir_e             res_dir;

  assign frame_end = vsync_q & ~vsync;
  assign pix       = active & is_orange;
  // Only a frame end seen while idle is processed; others count as overrun.
  assign accept    = frame_end & (state_q == ST_ACC);
  // The divider launches straight off the live accumulators on the frame-end
  // edge (its operand registers are the sum snapshot); the FSM makes the same
  // decision one cycle later from the registered count snapshot.
  assign div_start = accept & (cnt_q >= MIN_CNT);

  seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .done     (div_done),
    .quotient (quo)
  );

  // Pixel x counter and saturating accumulators.
  always_comb begin
    x_d      = active ? ((x_q == X_MAX) ? x_q : x_q + X_W'(1)) : '0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    sum_wide = {1'b0, sum_q} + {{(SUM_W + 1 - X_W){1'b0}}, x_q};
    sum_inc  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];

    if (frame_end) begin
      // The pixel on the frame-end cycle already belongs to the new frame.
      cnt_d = pix ? CNT_W'(1) : '0;
      sum_d = pix ? {{(SUM_W - X_W){1'b0}}, x_q} : '0;
    end else begin
      cnt_d = pix ? cnt_inc : cnt_q;
      sum_d = pix ? sum_inc : sum_q;
    end

    snap_cnt_d = accept ? cnt_q : snap_cnt_q;
    fe_pend_d  = accept;
    ovr_d      = ovr_q | (frame_end & (state_q != ST_ACC));
  end

  // Quotient clamped into the visible line range.
  always_comb begin
    cx_clamp = (quo > CX_LIM) ? CX_LIM[X_W-1:0] : quo[X_W-1:0];
  end

  // FSM next state and publish logic.
  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    dir_d   = dir_q;
    cx_d    = cx_q;
    ocnt_d  = ocnt_q;
    fv_d    = 1'b0;
    res_dir = DIR_NONE;
`ifdef CENTROID_HYST_EN
    pend_d  = pend_q;
`endif

    unique case (state_q)
      ST_ACC: begin
        if (fe_pend_q) state_d = (snap_cnt_q >= MIN_CNT) ? ST_DIV : ST_PUB;
      end
      ST_DIV: begin
        if (div_done) state_d = ST_PUB;
      end
      ST_PUB: begin
        state_d = ST_ACC;
        fv_d    = 1'b1;
        ocnt_d  = snap_cnt_q;
        if (snap_cnt_q >= MIN_CNT) begin
          det_d   = 1'b1;
          cx_d    = cx_clamp;
          res_dir = zone_dir(cx_clamp, H_ACTIVE);
        end else begin
          det_d   = 1'b0;
          res_dir = DIR_NONE;
        end
`ifdef CENTROID_HYST_EN
        // A none result is published at once; a new direction must repeat.
        if (res_dir == DIR_NONE) begin
          dir_d  = DIR_NONE;
          pend_d = DIR_NONE;
        end else if (res_dir == dir_q) begin
          pend_d = DIR_NONE;
        end else if (res_dir == pend_q) begin
          dir_d  = res_dir;
          pend_d = DIR_NONE;
        end else begin
          pend_d = res_dir;
        end
`else
        dir_d = res_dir;
`endif
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      x_q        <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      snap_cnt_q <= '0;
      fe_pend_q  <= 1'b0;
      state_q    <= ST_ACC;
      det_q      <= 1'b0;
      dir_q      <= DIR_NONE;
      cx_q       <= '0;
      ocnt_q     <= '0;
      fv_q       <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef CENTROID_HYST_EN
      pend_q     <= DIR_NONE;
`endif
    end else begin
      vsync_q    <= vsync;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      snap_cnt_q <= snap_cnt_d;
      fe_pend_q  <= fe_pend_d;
      state_q    <= state_d;
      det_q      <= det_d;
      dir_q      <= dir_d;
      cx_q       <= cx_d;
      ocnt_q     <= ocnt_d;
      fv_q       <= fv_d;
      ovr_q      <= ovr_d;
`ifdef CENTROID_HYST_EN
      pend_q     <= pend_d;
`endif
    end
  end

  assign orange_detected = det_q;
  assign direction       = dir_q;
  assign centroid_x      = cx_q;
  assign orange_count    = ocnt_q;
  assign frame_valid     = fv_q;
  assign overrun         = ovr_q;

endmodule
